acc_cpu_core: RTL

//   Accumulator CPU that drives the 4096x16 program/data RAM. It fetches 16-bit

---
 rtl/acc_cpu_core.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_core.sv
// -----------------------------------------------------------------------------
// acc_cpu_core
//
// Accumulator CPU that sits directly upstream of a 4096x16 program/data RAM.
// Instruction format: opcode[15:12] | operand[11:0].
//
// Each instruction is fetched in one cycle (FETCH) and executed in the next
// (EXEC). I/O instructions then wait in IN_WAIT / OUT_WAIT for their valid/ready
// handshake. HALT is terminal until reset.
//
// Opcodes:
//   0 NOP, 1 LD, 2 ADD, 3 ST, 4 SUB, E HALT,
//   F with operand IO_IN_CODE  -> INPUT  (ACC <= in_data)
//   F with operand IO_OUT_CODE -> OUTPUT (out_data <= ACC)
//   5 JMP, 6 JZ, 7 JN          -> only when CPU_JUMP_EN is defined, else NOP
//
// Build option:
//   CPU_JUMP_EN  define to enable the branch opcodes 5/6/7.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   mem_addr   out  12  RAM address (PC in FETCH, IR[11:0] otherwise)
//   mem_load   out  1   RAM write enable (EXEC of ST only)
//   mem_d      out  16  RAM write data (always ACC)
//   mem_q      in   16  RAM read data, same-cycle combinational read
//   in_data    in   16  input word
//   in_valid   in   1   input word available
//   in_ready   out  1   core accepts in_data this cycle
//   out_data   out  16  output word (registered)
//   out_valid  out  1   out_data valid, held until accepted
//   out_ready  in   1   consumer accepts out_data
//   halted     out  1   core is in HALT (registered)
// -----------------------------------------------------------------------------
module acc_cpu_core #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter logic [11:0] IO_IN_CODE  = 12'h001,
    parameter logic [11:0] IO_OUT_CODE = 12'h002
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] mem_addr,
    output logic        mem_load,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        halted
);

    // -------------------------------------------------------------------------
    // Opcode encoding
    // -------------------------------------------------------------------------
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_IO   = 4'hF;
`ifdef CPU_JUMP_EN
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_JN   = 4'h7;
`endif

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_EXEC     = 3'd1,
        ST_IN_WAIT  = 3'd2,
        ST_OUT_WAIT = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Architectural state
    // -------------------------------------------------------------------------
    state_t      state_reg;
    logic [11:0] pc_reg;
    logic [15:0] acc_reg;
    logic [15:0] ir_reg;
    logic [15:0] out_data_reg;
    logic        out_valid_reg;
    logic        halted_reg;

    logic [3:0]  opcode;
    logic [11:0] operand;

    assign opcode  = ir_reg[15:12];
    assign operand = ir_reg[11:0];

    // -------------------------------------------------------------------------
    // Combinational outputs
    // -------------------------------------------------------------------------
    // The RAM is addressed by the PC only while fetching; every other state
    // (including the wait states and HALT) points at the instruction operand.
    assign mem_addr = (state_reg == ST_FETCH) ? pc_reg : operand;

    // The write strobe and input-ready are gated by rst so nothing leaks to
    // the RAM or the producer during the reset cycle itself.
    assign mem_load = !rst && (state_reg == ST_EXEC) && (opcode == OP_ST);
    assign mem_d    = acc_reg;
    assign in_ready = !rst && (state_reg == ST_IN_WAIT);

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign halted    = halted_reg;

    // -------------------------------------------------------------------------
    // Control FSM and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= RESET_PC;
            acc_reg       <= 16'h0000;
            ir_reg        <= 16'h0000;
            out_data_reg  <= 16'h0000;
            out_valid_reg <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    // 12-bit PC wraps naturally from FFF to 000.
                    ir_reg    <= mem_q;
                    pc_reg    <= pc_reg + 12'd1;
                    state_reg <= ST_EXEC;
                end

                ST_EXEC: begin
                    // Default: straight back to FETCH; the cases below only
                    // override the destination for HALT and I/O.
                    state_reg <= ST_FETCH;
                    case (opcode)
                        OP_NOP: ;
                        OP_LD:  acc_reg <= mem_q;
                        OP_ADD: acc_reg <= acc_reg + mem_q;
                        OP_SUB: acc_reg <= acc_reg - mem_q;
                        OP_ST:  ;  // write is the combinational mem_load strobe
                        OP_HALT: begin
                            state_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                        end
                        OP_IO: begin
                            if (operand == IO_IN_CODE) begin
                                state_reg <= ST_IN_WAIT;
                            end else if (operand == IO_OUT_CODE) begin
                                out_data_reg  <= acc_reg;
                                out_valid_reg <= 1'b1;
                                state_reg     <= ST_OUT_WAIT;
                            end
                            // Unknown I/O selector behaves as NOP.
                        end
`ifdef CPU_JUMP_EN
                        // Branches overwrite the PC+1 already taken in FETCH.
                        OP_JMP: pc_reg <= operand;
                        OP_JZ: begin
                            if (acc_reg == 16'h0000) begin
                                pc_reg <= operand;
                            end
                        end
                        OP_JN: begin
                            if (acc_reg[15]) begin
                                pc_reg <= operand;
                            end
                        end
`endif
                        default: ;
                    endcase
                end

                ST_IN_WAIT: begin
                    // in_ready is high for the whole of this state.
                    if (in_valid) begin
                        acc_reg   <= in_data;
                        state_reg <= ST_FETCH;
                    end
                end

                ST_OUT_WAIT: begin
                    // out_data/out_valid stay frozen until the consumer takes
                    // the word; even an already-high out_ready costs this cycle.
                    if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_FETCH;
                    end
                end

                ST_HALT: begin
                    state_reg <= ST_HALT;
                end

                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
